// File: rtl/dir_ctrl.sv
// Button conditioner for the snake core: synchronise, debounce and edge-detect four
// buttons, filter illegal turns, and commit one legal heading change per move tick.
module dir_ctrl #(
   parameter int DEBOUNCE_CYCLES = 200000,
   parameter bit BTN_ACTIVE_LOW  = 1'b0
) (
   input  logic       clk,
   input  logic       clear_n,
   input  logic [3:0] btn,
   input  logic       mv_tick,
   output logic [1:0] heading,
   output logic [3:0] direction,
   output logic       dir_changed,
   output logic       pending_valid
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic [3:0]    btn_pol;
   logic [3:0]    sync1_q, sync2_q;
   logic [3:0]    db_q, db_d;
   logic [3:0]    db_dly_q;
   logic [3:0]    press_q, press_d;
   logic [CW-1:0] cnt_q [4];
   logic [CW-1:0] cnt_d [4];

   logic [1:0]    heading_q, heading_d;
   logic [3:0]    dir_q, dir_d;
   logic          dchg_q, dchg_d;
   logic [1:0]    pend_q, pend_d;
   logic          pv_q, pv_d;

   logic          cand_valid;
   logic [1:0]    cand;
   logic          commit;
   logic [1:0]    head_next;
   logic          accept;

   assign btn_pol = BTN_ACTIVE_LOW ? ~btn : btn;

   // Per-button debounce: db follows sync only after a full run of disagreeing cycles.
   always_comb begin
      db_d = db_q;
      for (int i = 0; i < 4; i++) begin
         cnt_d[i] = cnt_q[i];
         if (sync2_q[i] == db_q[i]) begin
            cnt_d[i] = '0;
         end else if (cnt_q[i] == CNT_LAST) begin
            db_d[i]  = sync2_q[i];
            cnt_d[i] = '0;
         end else begin
            cnt_d[i] = cnt_q[i] + 1'b1;
         end
      end
      press_d = db_q & ~db_dly_q;
   end

   // Fixed press priority: right > left > down > up.
   always_comb begin
      cand_valid = 1'b1;
      cand       = 2'b11;
      if (press_q[3])      cand = 2'b11;
      else if (press_q[0]) cand = 2'b00;
      else if (press_q[1]) cand = 2'b01;
      else if (press_q[2]) cand = 2'b10;
      else                 cand_valid = 1'b0;
   end

   // Legality is judged against the heading that will be in force after this edge,
   // so a tick-coincident press can never reverse the snake in one step.
   always_comb begin
      commit    = mv_tick & pv_q;
      head_next = commit ? pend_q : heading_q;
      accept    = cand_valid && (cand != head_next) && (cand != ~head_next);

      heading_d = head_next;
      dir_d     = 4'b0001 << head_next;
      dchg_d    = commit;
      pend_d    = accept ? cand : pend_q;
      pv_d      = accept | (pv_q & ~commit);
   end

   always_ff @(posedge clk or negedge clear_n) begin
      if (!clear_n) begin
         sync1_q   <= '0;
         sync2_q   <= '0;
         db_q      <= '0;
         db_dly_q  <= '0;
         press_q   <= '0;
         for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
         heading_q <= 2'b11;
         dir_q     <= 4'b1000;
         dchg_q    <= 1'b0;
         pend_q    <= 2'b11;
         pv_q      <= 1'b0;
      end else begin
         sync1_q   <= btn_pol;
         sync2_q   <= sync1_q;
         db_q      <= db_d;
         db_dly_q  <= db_q;
         press_q   <= press_d;
         for (int i = 0; i < 4; i++) cnt_q[i] <= cnt_d[i];
         heading_q <= heading_d;
         dir_q     <= dir_d;
         dchg_q    <= dchg_d;
         pend_q    <= pend_d;
         pv_q      <= pv_d;
      end
   end

   assign heading       = heading_q;
   assign direction     = dir_q;
   assign dir_changed   = dchg_q;
   assign pending_valid = pv_q;

endmodule
